// File: rtl/preg_freelist_ctrl_if.sv
// Allocation and release channels between rename/commit and
// the physical-register free list.
interface preg_freelist_ctrl_if #(
    parameter int TAG_W = 7
);
    logic             alloc_req;
    logic             alloc_gnt;
    logic [TAG_W-1:0] alloc_tag;
    logic             release_valid;
    logic [TAG_W-1:0] release_tag;

    modport master (
        output alloc_req,
        output release_valid,
        output release_tag,
        input  alloc_gnt,
        input  alloc_tag
    );

    modport slave (
        input  alloc_req,
        input  release_valid,
        input  release_tag,
        output alloc_gnt,
        output alloc_tag
    );
endinterface

// File: rtl/preg_freelist_ctrl.sv
// Circular free list of physical tags: one grant and one release
// per cycle, with INIT fill and single-cycle flush recovery.
module preg_freelist_ctrl #(
    parameter int NUM_ARCH = 64,
    parameter int DEPTH    = 16,
    parameter int TAG_W    = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    preg_freelist_ctrl_if.slave    fl,
    input  logic                   recovery,
    output logic [$clog2(DEPTH):0] free_count,
    output logic                   empty,
    output logic                   busy,
    output logic                   err_overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_RECOVER
    } state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [PW-1:0]    init_cnt_q, init_cnt_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [TAG_W-1:0] list_q [DEPTH];

    logic             run;
    logic             gnt;
    logic             push;
    logic             wr_en;
    logic [PW-1:0]    wr_idx;
    logic [TAG_W-1:0] wr_data;

    assign run  = (state_q == S_RUN);
    assign gnt  = fl.alloc_req && run && (cnt_q != '0) && !recovery;
    assign push = run && fl.release_valid && (cnt_q != FULL);

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        init_cnt_d = init_cnt_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        wr_en      = 1'b0;
        wr_idx     = tail_q;
        wr_data    = fl.release_tag;
        unique case (state_q)
            S_INIT: begin
                wr_en      = 1'b1;
                wr_idx     = init_cnt_q;
                wr_data    = TAG_W'(NUM_ARCH) + TAG_W'(init_cnt_q);
                init_cnt_d = init_cnt_q + 1'b1;
                cnt_d      = cnt_q + 1'b1;
                if (init_cnt_q == PW'(DEPTH - 1)) begin
                    state_d = S_RUN;
                    head_d  = '0;
                    tail_d  = '0;
                end
            end
            S_RUN: begin
                wr_en = push;
                if (push) tail_d = tail_q + 1'b1;
                if (fl.release_valid && cnt_q == FULL) err_d = 1'b1;
                if (gnt) head_d = head_q + 1'b1;
                cnt_d = cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, gnt};
                if (recovery) state_d = S_RECOVER;
            end
            S_RECOVER: begin
                // Speculative tags since the last commit point return as free
                head_d  = tail_q;
                cnt_d   = FULL;
                state_d = S_RUN;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_INIT;
            head_q     <= '0;
            tail_q     <= '0;
            init_cnt_q <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            init_cnt_q <= init_cnt_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && wr_en) list_q[wr_idx] <= wr_data;
    end

    assign fl.alloc_gnt = gnt;
    assign fl.alloc_tag = run ? list_q[head_q] : '0;
    assign free_count   = cnt_q;
    assign empty        = (cnt_q == '0);
    assign busy         = !run;
    assign err_overflow = err_q;

endmodule

// File: doc/preg_freelist_ctrl.md
Name: preg_freelist_ctrl

Overview:
Controls the physical-register free list shared by the rename logic (allocation) and the commit path (release). It holds a circular list of free physical tags and grants one allocation per cycle under a req/gnt handshake. It accepts one release per cycle from commit. On recovery it sequences the list back to its all-free state.

Parameters:
NUM_ARCH, 64, architectural registers (int+fp); tags 0..NUM_ARCH-1 are owned by the committed map at reset
DEPTH, 16, free-list entries; must be a power of two
TAG_W, 7, physical tag width; NUM_ARCH+DEPTH <= 2**TAG_W

Ports:
clk  in  1  clock; the block uses only this clock
rst  in  1  reset, synchronous, active-low
alloc_req  in  1  rename requests one tag this cycle
alloc_gnt  out  1  allocation granted; alloc_tag is valid and is consumed this cycle
alloc_tag  out  TAG_W  tag at the list head
release_valid  in  1  commit returns an old tag
release_tag  in  TAG_W  tag being returned
recovery  in  1  flush: all speculative allocations are discarded
free_count  out  $clog2(DEPTH)+1  number of free entries
empty  out  1  free_count==0
busy  out  1  block is in INIT or RECOVER
err_overflow  out  1  sticky; a release was made while the list was full

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst; asserted when rst==0 at a posedge clk).
- Reset values: state=INIT, head=0, tail=0, init_cnt=0, free_count=0, empty=1, busy=1, alloc_gnt=0, alloc_tag=0, err_overflow=0.
- States are INIT, RUN and RECOVER.
- INIT: writes list[init_cnt] <= NUM_ARCH+init_cnt, one entry per cycle, and increments free_count. After DEPTH cycles: head=0, tail=0, free_count=DEPTH, then the state moves to RUN. The first grant is therefore possible on cycle DEPTH+1 after rst deasserts. Releases and recovery are ignored in INIT.
- RUN, combinational outputs: alloc_tag = list[head]; alloc_gnt = alloc_req && state==RUN && free_count!=0.
- RUN, grant: head <= head+1 (wraps modulo DEPTH) and free_count decrements.
- RUN, release: if free_count<DEPTH, then list[tail] <= release_tag, tail <= tail+1 (wrap) and free_count increments. If free_count==DEPTH, the release is dropped and err_overflow <= 1.
- Grant and release in the same cycle: both take effect and free_count is unchanged. With free_count==0 there is no bypass: the grant is 0 and the release is accepted (free_count becomes 1).
- A release_tag of 0 is never pushed; commit filters architectural register x0.
- recovery=1 in RUN: any alloc this cycle is not granted (alloc_gnt is forced to 0). Any same-cycle release is still pushed first. The state moves to RECOVER.
- RECOVER (exactly one cycle): head <= tail and free_count <= DEPTH; the list contents are untouched; alloc_gnt=0; busy=1. Releases arriving in RECOVER are dropped, because commit is quiesced after a flush. The block then returns to RUN.
- recovery=1 while in RECOVER is ignored.
- rst asserted in any state, including mid-INIT or RECOVER, returns the block to the reset values and restarts INIT.
- free_count never exceeds DEPTH or goes below 0. Pointers are $clog2(DEPTH) bits and wrap naturally.
- The tag at the head must remain stable while alloc_req is held and no grant is given.

Test Plan:
- Reset, then 16 idle cycles: busy falls on cycle 16, free_count=16, and alloc_tag=64.
- Drain with alloc_req held for 17 cycles: tags 64..79 are granted in order; on the 17th cycle alloc_gnt=0 and empty=1.
- When empty, release_tag=5 with alloc_req: there is no grant that cycle; the next cycle gives alloc_gnt=1 and alloc_tag=5.
- Allocate 3 tags, release 2 (tags 10 and 11), then pulse recovery: alloc_gnt=0 for 2 cycles, then free_count=16, with head==tail.
- Pulse recovery while also releasing tag 20: tag 20 is written at the old tail; after RECOVER, free_count=16.
- With the list full, release tag 30: the release is dropped, err_overflow=1 and stays 1 until reset.
- Assert rst at INIT cycle 7: all outputs return to their reset values and INIT restarts at tag 64.
